nn_xor_sequencer: RTL

NN_XOR_SEQUENCER -- requirements
Module: nn_xor_sequencer

---
 rtl/nn_xor_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/nn_xor_sequencer.sv
// Sequencer around a fixed-latency float XOR network: loads nine parameter words,
// issues one operand pair at a time and returns the network result after LATENCY cycles.
module nn_xor_sequencer #(
    parameter int exp_width  = 8,
    parameter int mant_width = 24,
    parameter int LATENCY    = 32,
    localparam int data_width = exp_width + mant_width
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [data_width-1:0] cfg_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] in_a,
    input  logic [data_width-1:0] in_b,
    input  logic [2:0]            round_mode_in,
    output logic [data_width-1:0] w11,
    output logic [data_width-1:0] w12,
    output logic [data_width-1:0] w21,
    output logic [data_width-1:0] w22,
    output logic [data_width-1:0] b1,
    output logic [data_width-1:0] b2,
    output logic [data_width-1:0] w31,
    output logic [data_width-1:0] w32,
    output logic [data_width-1:0] b3,
    output logic [data_width-1:0] nn_a,
    output logic [data_width-1:0] nn_b,
    output logic [2:0]            round_mode,
    input  logic [data_width-1:0] nn_result,
    input  logic [4:0]            nn_exc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_result,
    output logic [4:0]            out_exc,
    output logic                  out_err,
    output logic                  cfg_done
);

    typedef enum logic [1:0] {
        S_CFG  = 2'd0,
        S_IDLE = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_index;
    logic [7:0]            r_counter;
    logic                  r_cfg_done;
    logic [data_width-1:0] r_param [0:8];
    logic [data_width-1:0] r_nn_a;
    logic [data_width-1:0] r_nn_b;
    logic [2:0]            r_round_mode;
    logic                  r_out_valid;
    logic [data_width-1:0] r_out_result;
    logic [4:0]            r_out_exc;
    logic                  r_out_err;
    logic                  w_cfg_fire;
    logic                  w_in_fire;
    logic                  w_out_fire;

    // Configuration always wins over a simultaneous operand pair in IDLE.
    assign cfg_ready  = (r_state == S_CFG) || (r_state == S_IDLE);
    assign in_ready   = (r_state == S_IDLE) && !cfg_valid;
    assign w_cfg_fire = cfg_valid && cfg_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    // Next-state selection.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_CFG: begin
                if (w_cfg_fire && (r_index == 4'd8)) w_next_state = S_IDLE;
                else                                 w_next_state = S_CFG;
            end
            S_IDLE: begin
                if (w_cfg_fire)     w_next_state = S_CFG;
                else if (w_in_fire) w_next_state = S_WAIT;
                else                w_next_state = S_IDLE;
            end
            S_WAIT: begin
                if (r_counter == 8'd0) w_next_state = S_RESP;
                else                   w_next_state = S_WAIT;
            end
            S_RESP: begin
                if (w_out_fire) w_next_state = S_IDLE;
                else            w_next_state = S_RESP;
            end
            default: w_next_state = S_CFG;
        endcase
    end

    // State register and latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_CFG;
            r_counter <= 8'd0;
        end else begin
            r_state <= w_next_state;
            if (w_in_fire)
                r_counter <= 8'(LATENCY - 1);
            else if ((r_state == S_WAIT) && (r_counter != 8'd0))
                r_counter <= r_counter - 8'd1;
        end
    end

    // Parameter load: an IDLE write restarts the sequence at w11.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_index    <= 4'd0;
            r_cfg_done <= 1'b0;
            for (int k = 0; k < 9; k++) r_param[k] <= '0;
        end else if (w_cfg_fire) begin
            if (r_state == S_IDLE) begin
                r_param[0] <= cfg_data;
                r_index    <= 4'd1;
                r_cfg_done <= 1'b0;
            end else if (r_index == 4'd8) begin
                r_param[8] <= cfg_data;
                r_index    <= 4'd0;
                r_cfg_done <= 1'b1;
            end else begin
                r_param[r_index] <= cfg_data;
                r_index          <= r_index + 4'd1;
            end
        end
    end

    // Operand issue registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nn_a       <= '0;
            r_nn_b       <= '0;
            r_round_mode <= 3'b000;
        end else if (w_in_fire) begin
            r_nn_a       <= in_a;
            r_nn_b       <= in_b;
            r_round_mode <= round_mode_in;
        end
    end

    // Result capture and response handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_exc    <= 5'd0;
            r_out_err    <= 1'b0;
        end else if ((r_state == S_WAIT) && (r_counter == 8'd0)) begin
            r_out_valid  <= 1'b1;
            r_out_result <= nn_result;
            r_out_exc    <= nn_exc;
            r_out_err    <= |nn_exc;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    assign w11        = r_param[0];
    assign w12        = r_param[1];
    assign w21        = r_param[2];
    assign w22        = r_param[3];
    assign b1         = r_param[4];
    assign b2         = r_param[5];
    assign w31        = r_param[6];
    assign w32        = r_param[7];
    assign b3         = r_param[8];
    assign nn_a       = r_nn_a;
    assign nn_b       = r_nn_b;
    assign round_mode = r_round_mode;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_exc    = r_out_exc;
    assign out_err    = r_out_err;
    assign cfg_done   = r_cfg_done;

endmodule
